// File: rtl/avaliador_jogada.sv
// avaliador_jogada: judges one player move in the note-memory game.
// Armed by the game FSM, it waits for a press, measures the hold time and
// checks note and duration against the expected values (asymmetric tolerance,
// optional duration bypass, timeout, multiple-press detection and abort).
module avaliador_jogada #(
  parameter int NUM_BOTOES     = 12,
  parameter int NOTA_W         = 4,
  parameter int TEMPO_W        = 16,
  parameter int TOL_BAIXO      = 400,
  parameter int TOL_CIMA       = 1000,
  parameter int TIMEOUT_CICLOS = 25000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  cancelar,
  input  logic [NOTA_W-1:0]     nota_esperada,
  input  logic [TEMPO_W-1:0]    tempo_esperado,
  input  logic                  verifica_tempo,
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic                  ocupado,
  output logic                  tocando,
  output logic                  pronto,
  output logic                  nota_correta,
  output logic                  tempo_correto,
  output logic                  timeout,
  output logic                  multiplas,
  output logic [NOTA_W-1:0]     nota_jogada,
  output logic [TEMPO_W-1:0]    duracao
);

  localparam int CONT_W = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    MEDE
  } estado_t;

  estado_t               r_estado;
  logic [NOTA_W-1:0]     r_notaEsp;
  logic [TEMPO_W-1:0]    r_tempoEsp;
  logic                  r_verifica;
  logic [CONT_W-1:0]     r_contTimeout;
  logic [NOTA_W-1:0]     r_notaJogada;
  logic [TEMPO_W-1:0]    r_duracao;
  logic                  r_multiplas;
  logic                  r_pronto;
  logic                  r_notaCorreta;
  logic                  r_tempoCorreto;
  logic                  r_timeout;

  logic [NOTA_W-1:0]     w_idxBaixo;
  logic                  w_variosBotoes;
  logic [NUM_BOTOES-1:0] w_maskCapt;
  logic                  w_capturadoAtivo;
  logic                  w_outrosAtivos;
  logic                  w_multFinal;
  logic                  w_durSat;
  logic [TEMPO_W:0]      w_limSup;
  logic [TEMPO_W-1:0]    w_limInf;
  logic                  w_duracaoOk;
  logic                  w_tempoOk;
  logic                  w_notaOk;

  // Priority encoder: index of the lowest pressed button
  always_comb begin
    w_idxBaixo = '0;
    for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
      if (botoes[i]) w_idxBaixo = NOTA_W'(i);
    end
  end

  // More than one bit set: clearing the lowest bit leaves something behind
  assign w_variosBotoes   = |(botoes & (botoes - NUM_BOTOES'(1)));
  assign w_maskCapt       = {{(NUM_BOTOES - 1){1'b0}}, 1'b1} << r_notaJogada;
  assign w_capturadoAtivo = |(botoes & w_maskCapt);
  assign w_outrosAtivos   = |(botoes & ~w_maskCapt);
  assign w_multFinal      = r_multiplas | w_outrosAtivos;
  assign w_durSat         = &r_duracao;

  // Upper bound one bit wider so it cannot wrap; lower bound clamps at zero
  assign w_limSup = {1'b0, r_tempoEsp} + (TEMPO_W + 1)'(TOL_CIMA);
  assign w_limInf = ({1'b0, r_tempoEsp} > (TEMPO_W + 1)'(TOL_BAIXO))
                    ? (r_tempoEsp - TEMPO_W'(TOL_BAIXO)) : '0;
  assign w_duracaoOk = (r_duracao >= w_limInf) && ({1'b0, r_duracao} <= w_limSup);
  assign w_tempoOk   = !r_verifica || w_duracaoOk;
  assign w_notaOk    = (r_notaJogada == r_notaEsp) && !w_multFinal;

  // Main FSM: arm, wait for press (with timeout), measure hold, publish results
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado       <= OCIOSO;
      r_notaEsp      <= '0;
      r_tempoEsp     <= '0;
      r_verifica     <= 1'b0;
      r_contTimeout  <= '0;
      r_notaJogada   <= '0;
      r_duracao      <= '0;
      r_multiplas    <= 1'b0;
      r_pronto       <= 1'b0;
      r_notaCorreta  <= 1'b0;
      r_tempoCorreto <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      if (cancelar) begin
        r_estado       <= OCIOSO;
        r_contTimeout  <= '0;
        r_notaJogada   <= '0;
        r_duracao      <= '0;
        r_multiplas    <= 1'b0;
        r_notaCorreta  <= 1'b0;
        r_tempoCorreto <= 1'b0;
        r_timeout      <= 1'b0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (iniciar) begin
              r_notaEsp      <= nota_esperada;
              r_tempoEsp     <= tempo_esperado;
              r_verifica     <= verifica_tempo;
              r_contTimeout  <= '0;
              r_notaJogada   <= '0;
              r_duracao      <= '0;
              r_multiplas    <= 1'b0;
              r_notaCorreta  <= 1'b0;
              r_tempoCorreto <= 1'b0;
              r_timeout      <= 1'b0;
              r_estado       <= ESPERA;
            end
          end
          ESPERA: begin
            if (botoes != '0) begin
              r_notaJogada <= w_idxBaixo;
              r_multiplas  <= w_variosBotoes;
              r_duracao    <= TEMPO_W'(1);
              r_estado     <= MEDE;
            end else if (r_contTimeout == CONT_W'(TIMEOUT_CICLOS - 1)) begin
              r_timeout      <= 1'b1;
              r_notaCorreta  <= 1'b0;
              r_tempoCorreto <= 1'b0;
              r_pronto       <= 1'b1;
              r_estado       <= OCIOSO;
            end else begin
              r_contTimeout <= r_contTimeout + CONT_W'(1);
            end
          end
          MEDE: begin
            if (w_capturadoAtivo) begin
              if (!w_durSat) r_duracao <= r_duracao + TEMPO_W'(1);
              if (w_outrosAtivos) r_multiplas <= 1'b1;
            end else begin
              r_multiplas    <= w_multFinal;
              r_notaCorreta  <= w_notaOk;
              r_tempoCorreto <= w_tempoOk;
              r_pronto       <= 1'b1;
              r_estado       <= OCIOSO;
            end
          end
          default: r_estado <= OCIOSO;
        endcase
      end
    end
  end

  assign ocupado       = (r_estado == ESPERA) || (r_estado == MEDE);
  assign tocando       = (r_estado == MEDE);
  assign pronto        = r_pronto;
  assign nota_correta  = r_notaCorreta;
  assign tempo_correto = r_tempoCorreto;
  assign timeout       = r_timeout;
  assign multiplas     = r_multiplas;
  assign nota_jogada   = r_notaJogada;
  assign duracao       = r_duracao;

endmodule
